parameters_expander: RTL and testbench

- Inverse of the fit-parameter rounding stage.
- Accepts packed rounded track-parameter words {phi, c, d} and restores full-width two's-complement values.
  - c and d arrive as sign-magnitude at one bit less; phi arrives as two's complement at one bit less.
- Sits on the readback/spy path, feeding monitoring and comparison logic.
- Two-stage valid/ready pipeline with backpressure, full throughput, plus an output transfer counter.

---
 rtl/parameters_expander_pkg.sv | 29 ++
 rtl/parameters_expander_sm_expand.sv | 20 ++
 rtl/parameters_expander.sv | 106 ++++++++++
 tb/tb_parameters_expander.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parameters_expander_pkg.sv
// Shared widths, packed-word layouts and field offsets for the parameter
// rounder/expander pair.
package parameters_expander_pkg;

    localparam int PHIWIDTH = 14;
    localparam int DWIDTH   = 11;
    localparam int CWIDTH   = 10;
    localparam int CNTWIDTH = 16;

    localparam int RND_WIDTH  = PHIWIDTH + DWIDTH + CWIDTH - 3;
    localparam int FULL_WIDTH = PHIWIDTH + DWIDTH + CWIDTH;

    // Rounded layout {phi, c_sm, d_sm}, d in the LSBs.
    localparam int RND_D_LSB   = 0;
    localparam int RND_C_LSB   = DWIDTH - 1;
    localparam int RND_PHI_LSB = RND_C_LSB + CWIDTH - 1;

    // Full layout {phi, c, d}, d in the LSBs.
    localparam int FULL_D_LSB   = 0;
    localparam int FULL_C_LSB   = DWIDTH;
    localparam int FULL_PHI_LSB = DWIDTH + CWIDTH;

    typedef struct packed {
        logic [PHIWIDTH-1:0] phi;
        logic [CWIDTH-1:0]   c;
        logic [DWIDTH-1:0]   d;
    } full_word_t;

endpackage

// File: rtl/parameters_expander_sm_expand.sv
// Restores a W-1 bit sign-magnitude field to a W-bit two's-complement value
// at twice the magnitude, flagging the negative-zero code.
module parameters_expander_sm_expand #(
    parameter int W = 11
) (
    input  logic [W-2:0] sm,
    output logic [W-1:0] value,
    output logic         negzero
);

    logic         sign;
    logic [W-1:0] m2;

    assign sign    = sm[W-2];
    assign m2      = {1'b0, sm[W-3:0], 1'b0};
    // Negating zero gives zero, so the negative-zero code expands to 0 for free.
    assign value   = sign ? -m2 : m2;
    assign negzero = sign && (sm[W-3:0] == '0);

endmodule

// File: rtl/parameters_expander.sv
// Two-stage valid/ready expander from rounded {phi, c_sm, d_sm} words to
// full-width {phi, c, d}. Optional negative-zero counter: PARAMETERS_EXPANDER_NEGZERO_CNT_EN.
module parameters_expander #(
    parameter int PHIWIDTH = parameters_expander_pkg::PHIWIDTH,
    parameter int DWIDTH   = parameters_expander_pkg::DWIDTH,
    parameter int CWIDTH   = parameters_expander_pkg::CWIDTH,
    parameter int CNTWIDTH = parameters_expander_pkg::CNTWIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [PHIWIDTH+DWIDTH+CWIDTH-4:0]    in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [PHIWIDTH+DWIDTH+CWIDTH-1:0]    out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CNTWIDTH-1:0]                  word_count
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    ,
    output logic [CNTWIDTH-1:0]                  negzero_count
`endif
);

    localparam int IN_W  = PHIWIDTH + DWIDTH + CWIDTH - 3;
    localparam int C_LSB = DWIDTH - 1;

    // Handshake: a word moves on a cycle where valid & ready are both high;
    // a producer holds valid and data steady until that cycle; ready never
    // depends on the same port's valid.
    logic            s1_valid;
    logic [IN_W-1:0] s1_data;
    logic            s2_adv;

    logic [DWIDTH-1:0] d_full;
    logic [CWIDTH-1:0] c_full;
    logic              d_negzero;
    logic              c_negzero;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    parameters_expander_sm_expand #(.W(DWIDTH)) u_expand_d (
        .sm      (s1_data[DWIDTH-2:0]),
        .value   (d_full),
        .negzero (d_negzero)
    );

    parameters_expander_sm_expand #(.W(CWIDTH)) u_expand_c (
        .sm      (s1_data[C_LSB +: CWIDTH-1]),
        .value   (c_full),
        .negzero (c_negzero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= {s1_data[IN_W-1 -: PHIWIDTH-1], 1'b0, c_full, d_full};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_count <= '0;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + CNTWIDTH'(1);
        end
    end

`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    logic s2_nz_d;
    logic s2_nz_c;

    // Flags travel with the word in stage 2 so the count tracks output transfers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_nz_d       <= 1'b0;
            s2_nz_c       <= 1'b0;
            negzero_count <= '0;
        end else begin
            if (s2_adv && s1_valid) begin
                s2_nz_d <= d_negzero;
                s2_nz_c <= c_negzero;
            end
            if (out_valid && out_ready && (s2_nz_d || s2_nz_c) && (negzero_count != '1)) begin
                negzero_count <= negzero_count + CNTWIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_parameters_expander.sv
// Randomized bench for parameters_expander with an arithmetic reference model
// and a scoreboard queue. Define PARAMETERS_EXPANDER_NEGZERO_CNT_EN to cover the counter.
module tb_parameters_expander;
  import parameters_expander_pkg::*;

  logic                  clock;
  logic                  reset;
  logic [RND_WIDTH-1:0]  in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [FULL_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNTWIDTH-1:0]   word_count;
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
  logic [CNTWIDTH-1:0]   negzero_count;
`endif

  parameters_expander dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .word_count (word_count)
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    ,
    .negzero_count (negzero_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [FULL_WIDTH-1:0] exp_q[$];
  logic                  nz_q[$];
  int                    occ = 0;
  logic [CNTWIDTH-1:0]   model_cnt = '0;
  logic [CNTWIDTH-1:0]   nz_cnt = '0;
  logic                  hold_valid = 1'b0;
  logic [FULL_WIDTH-1:0] hold_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: value = +/- 2*magnitude, phi doubled, each truncated to its field width.
  function automatic logic [FULL_WIDTH-1:0] expand(input logic [RND_WIDTH-1:0] w);
    int d_mag, c_mag, dv, cv, pv;
    full_word_t r;
    d_mag = int'({23'd0, w[RND_D_LSB +: DWIDTH-2]});
    dv    = w[RND_D_LSB + DWIDTH-2] ? -(2 * d_mag) : 2 * d_mag;
    c_mag = int'({24'd0, w[RND_C_LSB +: CWIDTH-2]});
    cv    = w[RND_C_LSB + CWIDTH-2] ? -(2 * c_mag) : 2 * c_mag;
    pv    = int'({19'd0, w[RND_PHI_LSB +: PHIWIDTH-1]}) * 2;
    r.d   = dv[DWIDTH-1:0];
    r.c   = cv[CWIDTH-1:0];
    r.phi = pv[PHIWIDTH-1:0];
    return r;
  endfunction

  function automatic logic is_negzero(input logic [RND_WIDTH-1:0] w);
    logic [DWIDTH-2:0] d_sm;
    logic [CWIDTH-2:0] c_sm;
    d_sm = w[RND_D_LSB +: DWIDTH-1];
    c_sm = w[RND_C_LSB +: CWIDTH-1];
    return (d_sm == 10'h200) || (c_sm == 9'h100);
  endfunction

  function automatic logic [RND_WIDTH-1:0] gen_word(input int mode);
    logic [RND_WIDTH-1:0] w;
    w = RND_WIDTH'($urandom);
    if (mode == 2) begin
      w[RND_D_LSB +: DWIDTH-1] = 10'h200;
    end else begin
      case ($urandom_range(0, 7))
        0: w[RND_D_LSB +: DWIDTH-1] = 10'h200;
        1: w[RND_C_LSB +: CWIDTH-1] = 9'h100;
        2: w[RND_D_LSB +: DWIDTH-1] = 10'h3FF;
        3: w[RND_PHI_LSB +: PHIWIDTH-1] = 13'h1FFF;
        default: ;
      endcase
    end
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (reset) begin
      check("in_ready", in_ready, !(occ == 2 && !out_ready));
      check("word_count", word_count, model_cnt);
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
      check("negzero_count", negzero_count, nz_cnt);
`endif
      if (hold_valid) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("out_data", out_data, exp_q.pop_front());
          if (nz_q.pop_front() && nz_cnt != '1) nz_cnt++;
        end
        model_cnt++;
        occ--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(expand(in_data));
        nz_q.push_back(is_negzero(in_data));
        occ++;
      end
      hold_valid = out_valid && !out_ready;
      hold_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete();
    nz_q.delete();
    occ        = 0;
    model_cnt  = '0;
    nz_cnt     = '0;
    hold_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic apply_one(input logic [RND_WIDTH-1:0] w, input logic [DWIDTH-1:0] ed,
                           input logic [CWIDTH-1:0] ec, input logic [PHIWIDTH-1:0] ep);
    full_word_t o;
    out_ready = 1'b1;
    in_data   = w;
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("lat_early", out_valid, 0);
    @(posedge clock);
    @(negedge clock);
    o = out_data;
    check("lat_valid", out_valid, 1);
    check("field_d", o.d, ed);
    check("field_c", o.c, ec);
    check("field_phi", o.phi, ep);
    @(posedge clock);
    #1;
  endtask

  // mode 0: random valid/ready, 1: ready pattern 1,0,0,1, 2: full rate with negzero d
  task automatic drive_stream(input int n, input int mode);
    int   sent = 0;
    int   k = 0;
    logic fire = 1'b0;
    in_data  = gen_word(mode);
    in_valid = 1'b0;
    while (sent < n && k < n * 20 + 100) begin
      if (!in_valid || mode != 0) in_valid = (mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = (k % 4 == 0) || (k % 4 == 3);
        default: out_ready = 1'b1;
      endcase
      #1 fire = in_valid && in_ready;
      @(posedge clock);
      #1;
      if (fire) begin
        sent++;
        in_data  = gen_word(mode);
        in_valid = (mode == 0) ? 1'b0 : in_valid;
      end
      k++;
    end
    in_valid = 1'b0;
    check("stream_sent", sent, n);
  endtask

  task automatic drain(input int mode);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      out_ready = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      @(posedge clock);
      #1;
      k++;
    end
    out_ready = 1'b1;
    @(negedge clock);
    check("drain_left", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    check("rst_negzero_count", negzero_count, 0);
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;

    // negative zero first so the counter step is from a known 0
    apply_one({13'h0000, 9'h100, 10'h200}, 11'h000, 10'h000, 14'h0000);
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    check("negzero_step", negzero_count, 1);
`endif
    apply_one({13'h0001, 9'h005, 10'h003}, 11'h006, 10'h00A, 14'h0002);
    apply_one({13'h0000, 9'h105, 10'h203}, 11'h7FA, 10'h3F6, 14'h0000);
    apply_one({13'h1FFF, 9'h0FF, 10'h1FF}, 11'h3FE, 10'h1FE, 14'h3FFE);
    apply_one({13'h0AAA, 9'h1FF, 10'h3FF}, 11'h402, 10'h202, 14'h1554);
    check("directed_count", word_count, 5);

    drive_stream(400, 0);
    drain(0);

    do_reset();
    drive_stream(8, 1);
    drain(1);
    check("bp_word_count", word_count, 8);

    // reset with two words in flight
    out_ready = 1'b0;
    in_data   = gen_word(0);
    in_valid  = 1'b1;
    @(posedge clock);
    #1 in_data = gen_word(0);
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    check("inflight_valid", out_valid, 1);
    check("inflight_full", in_ready, 0);
    reset = 1'b0;
    clear_model();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_word_count", word_count, 0);
    check("midrst_in_ready", in_ready, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    apply_one({13'h0003, 9'h001, 10'h201}, 11'h7FE, 10'h002, 14'h0006);

    // counter wrap
    do_reset();
    drive_stream(65537, 2);
    drain(2);
    check("wrap_word_count", word_count, 1);
`ifdef PARAMETERS_EXPANDER_NEGZERO_CNT_EN
    check("negzero_saturate", negzero_count, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
